// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver for the Morse encoder front end.
// The raw rx pin is synchronised before use. Bits are sampled at their
// centres, found from a half-bit offset after the start-bit edge. Each good
// byte is published through a ready/ack holding register. Framing errors and
// overruns are reported as one-cycle pulses; a framing error never delivers a
// byte.
//
// Handshake (ready/ack): ready=1 means data holds a byte the consumer has not
// yet taken. The consumer asserts ack, either as a pulse or as a level, to
// take it. ready falls on the first clock edge that samples ack=1, unless a
// new byte commits on that same edge. In that case the new byte is loaded,
// ready stays 1 and no overrun is flagged, because the old byte was taken.
// ack while ready=0 has no effect. The receiver never waits for ack. A byte
// that completes while the previous one is still unconsumed overwrites it,
// and overrun pulses once.
module uart_rx_byte #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  // Bit timing, derived from the clock and baud rate. Truncation is intended.
  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [13:0] BIT_LAST     = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST    = 14'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser flops. Both reset to the idle-high line level.
  logic rx_meta_q;
  logic rx_s_q;

  // FSM state.
  state_t state_q, state_d;

  // Timing and deserialiser registers.
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;

  // Stop-bit outcome. A good stop bit arms a commit on the following edge.
  logic commit_q, commit_d;
  logic frame_err_q, frame_err_d;

  // Output holding register and handshake flags.
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       overrun_q, overrun_d;

  // Counter terminal counts for the half-bit and full-bit waits.
  logic half_done;
  logic bit_done;

  // Two-flop synchroniser. Nothing downstream looks at raw rx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Terminal-count decode for the shared cycle counter.
  always_comb begin
    half_done = (cnt_q == HALF_LAST);
    bit_done  = (cnt_q == BIT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // If the line is still low at the start-bit centre, this is a real
        // frame. Otherwise it was a glitch.
        if (half_done) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_d = rx_s_q ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        // A held-low line must go high again before a new start is accepted.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: counter, bit index, shifter and stop-bit result controls.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = 14'd0;
        bit_idx_d = 3'd0;
      end
      S_START: begin
        if (half_done) begin
          cnt_d     = 14'd0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d              = 14'd0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = 14'd0;
          if (rx_s_q) begin
            commit_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      S_BREAK: begin
        cnt_d = 14'd0;
      end
      default: begin
        cnt_d     = 14'd0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Datapath registers that follow the FSM output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 14'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Handshake next-state logic. A commit takes priority over ack.
  always_comb begin
    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = 1'b0;
    if (commit_q) begin
      data_d    = shift_q;
      ready_d   = 1'b1;
      overrun_d = ready_q && !ack;
    end else if (ack) begin
      ready_d = 1'b0;
    end
  end

  // Output holding register and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign data      = data_q;
  assign ready     = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte. It uses a scaled bit rate of 50 clocks per bit
// so that every frame is short.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 5_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;      // 50
  localparam int HALF     = CPB / 2;              // 25
  // Posedges from the rx falling edge until ready rises.
  localparam int LAT      = 4 + HALF + 9 * CPB;   // 479

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_ok;
    logic       ack_before;
    logic [7:0] exp_data;
    logic       exp_ready;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[7];

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ack       (ack),
    .data      (data),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800us;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  // Pulse monitor. Counts frame_err and overrun pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive bits LSB first. The caller must already be on a negedge.
  task automatic send_bits(input logic [9:0] fr, input int nbits, input int period);
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (period) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int period);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    @(negedge clk);
    send_bits(fr, 10, period);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy === 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int         lat;
    int         k;
    int         fe0;
    int         ov0;
    logic       in_range;
    logic [9:0] fr;
    logic [7:0] m_data;
    logic       m_ready;
    int         m_fe;
    int         m_ov;

    vecs[0] = '{8'h41, 1'b1, 1'b0, 8'h41, 1'b1, 0, 0};
    vecs[1] = '{8'h30, 1'b1, 1'b1, 8'h30, 1'b1, 0, 0};
    vecs[2] = '{8'h39, 1'b1, 1'b0, 8'h39, 1'b1, 0, 1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1, 0};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 0};

    // Reset values.
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    #100;
    check("rst_data", 32'(data), 32'h00);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Test 1: 'A' with slightly long bits, latency, ack, and ack while idle.
    lat = 0;
    fork
      send_frame(8'h41, 1'b1, CPB + 1);
      begin
        @(negedge clk);
        while (lat < LAT + 20) begin
          @(posedge clk);
          #1;
          lat++;
          if (ready) break;
        end
      end
    join
    in_range = (lat >= LAT - 1) && (lat <= LAT + 1);
    if (!in_range) $display("latency observed %0d cycles", lat);
    check("t1_latency_in_range", 32'(in_range), 32'd1);
    wait_idle(CPB);
    check("t1_data", 32'(data), 32'h41);
    check("t1_ready", 32'(ready), 32'd1);
    check("t1_frame_err_cnt", 32'(fe_cnt), 32'd0);
    check("t1_overrun_cnt", 32'(ov_cnt), 32'd0);
    pulse_ack();
    check("t1_ack_ready", 32'(ready), 32'd0);
    check("t1_ack_data", 32'(data), 32'h41);
    pulse_ack();
    check("t1_ack_idle_ready", 32'(ready), 32'd0);
    check("t1_ack_idle_data", 32'(data), 32'h41);

    // Test 2: a low glitch shorter than half a bit is rejected.
    fe0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (15) @(negedge clk);
    check("t2_glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    k = 0;
    while (busy && k < HALF + 3) begin
      @(negedge clk);
      k++;
    end
    check("t2_busy_fell", 32'(busy), 32'd0);
    check("t2_ready", 32'(ready), 32'd0);
    check("t2_no_frame_err", 32'(fe_cnt), 32'(fe0));

    // Test 3: bad stop bit, then line held low (break), then a good frame.
    send_frame(8'h55, 1'b0, CPB);
    repeat (300) @(negedge clk);
    check("t3_break_busy", 32'(busy), 32'd1);
    check("t3_fe_once", 32'(fe_cnt), 32'(fe0 + 1));
    check("t3_ready", 32'(ready), 32'd0);
    rx = 1'b1;
    wait_idle(10);
    send_frame(8'h0A, 1'b1, CPB);
    wait_idle(CPB);
    repeat (2) @(negedge clk);
    check("t3_next_data", 32'(data), 32'h0A);
    check("t3_next_ready", 32'(ready), 32'd1);
    check("t3_fe_still_once", 32'(fe_cnt), 32'(fe0 + 1));
    pulse_ack();

    // Table-driven frames. These include 0x30/0x39 without ack (overrun).
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ack_before) pulse_ack();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].byte_v, vecs[i].stop_ok, CPB);
      if (!vecs[i].stop_ok) begin
        repeat (20) @(negedge clk);
        rx = 1'b1;
      end
      wait_idle(CPB);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_ov", i), 32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
    end

    // Test 5: ack on the exact commit cycle while ready is still set.
    ov0 = ov_cnt;
    send_frame(8'h7A, 1'b1, CPB);
    repeat (2) @(negedge clk);
    check("t5_prior_data", 32'(data), 32'h7A);
    check("t5_prior_overrun", 32'(ov_cnt - ov0), 32'd1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h20, 1'b1, CPB);
      begin
        @(negedge clk);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("t5_data", 32'(data), 32'h20);
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Test 6: reset during data bit 4 of 0x61, then receive 0x62.
    fr = {1'b1, 8'h61, 1'b0};
    @(negedge clk);
    send_bits(fr, 5, CPB);
    rx = fr[5];
    repeat (HALF) @(negedge clk);
    check("t6_busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_data", 32'(data), 32'h00);
    check("t6_rst_ready", 32'(ready), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_frame_err", 32'(frame_err), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h62, 1'b1, CPB);
    wait_idle(CPB);
    repeat (2) @(negedge clk);
    check("t6_data", 32'(data), 32'h62);
    check("t6_ready", 32'(ready), 32'd1);

    // Random frames against a reference model of the delivered byte.
    m_data  = 8'h62;
    m_ready = 1'b1;
    m_fe    = fe_cnt;
    m_ov    = ov_cnt;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       good;
      logic       ackb;
      int         per;
      int         gap;
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      ackb = 1'($urandom_range(0, 1));
      per  = $urandom_range(CPB - 1, CPB + 1);
      gap  = $urandom_range(0, 20);
      if (ackb) m_ready = 1'b0;
      if (good) begin
        if (m_ready) m_ov++;
        m_data  = b;
        m_ready = 1'b1;
      end else begin
        m_fe++;
      end
      exp_q.push_back(m_data);

      repeat (gap) @(negedge clk);
      if (ackb) pulse_ack();
      send_frame(b, good, per);
      if (!good) begin
        repeat ($urandom_range(5, 60)) @(negedge clk);
        rx = 1'b1;
      end
      wait_idle(CPB);
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_data", i), 32'(data), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_ready", i), 32'(ready), 32'(m_ready));
      check($sformatf("rnd%0d_fe", i), 32'(fe_cnt), 32'(m_fe));
      check($sformatf("rnd%0d_ov", i), 32'(ov_cnt), 32'(m_ov));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
